// File: rtl/fifo_bram_ctrl.sv
// First-word-fall-through FIFO controller for an external two-port BRAM.
// Port A read latency is absorbed by a P/O/S pipeline so the output stream runs at full rate.
module fifo_bram_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 12
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              wr_valid,
   output logic              wr_ready,
   input  logic [DATA_W-1:0] wr_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic [ADDR_W:0]   count,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_waddr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [ADDR_W-1:0] mem_raddr,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

   logic [ADDR_W:0]   wptr, rptr, ram_occ;
   logic              p_vld, o_vld, s_vld;
   logic [DATA_W-1:0] o_data, s_data;
   logic              full, ram_empty, push, pop, issue, o_free;
   logic [1:0]        held;

   assign ram_occ   = wptr - rptr;
   assign full      = (ram_occ == DEPTH);
   assign ram_empty = (ram_occ == '0);

   assign wr_ready  = !full && !reset;
   assign push      = wr_valid && wr_ready;
   assign mem_we    = push;
   assign mem_waddr = wptr[ADDR_W-1:0];
   assign mem_wdata = wr_data;

   assign rd_valid  = o_vld;
   assign rd_data   = o_data;
   assign pop       = o_vld && rd_ready;
   assign o_free    = !o_vld || pop;
   assign mem_raddr = rptr[ADDR_W-1:0];

   // Never let more than two words sit in P/O/S after this edge.
   assign held  = {1'b0, p_vld} + {1'b0, o_vld} + {1'b0, s_vld};
   assign issue = !ram_empty && ((held - {1'b0, pop}) <= 2'd1);
   assign count = ram_occ + (ADDR_W+1)'(held);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wptr   <= '0;
         rptr   <= '0;
         p_vld  <= 1'b0;
         o_vld  <= 1'b0;
         s_vld  <= 1'b0;
         o_data <= '0;
         s_data <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         p_vld <= 1'b0;
         o_vld <= 1'b0;
         s_vld <= 1'b0;
      end else begin
         if (push)  wptr <= wptr + 1'b1;
         if (issue) rptr <= rptr + 1'b1;
         p_vld <= issue;
         // Skid word is older than the in-flight word, so it always goes first.
         if (s_vld && o_free) begin
            o_vld  <= 1'b1;
            o_data <= s_data;
            s_vld  <= p_vld;
            s_data <= mem_rdata;
         end else if (p_vld && o_free) begin
            o_vld  <= 1'b1;
            o_data <= mem_rdata;
         end else begin
            if (o_free) o_vld <= 1'b0;
            if (p_vld) begin
               s_vld  <= 1'b1;
               s_data <= mem_rdata;
            end
         end
      end
   end

endmodule
